lcd_frame_sequencer: RTL

//   Master sequencer for the LCD command LUT. After reset it runs the panel init sequence
//   (SET_I/SEND_I), then on each frame request walks every grid cell, presenting cell_x/cell_y
//   (which feed the LUT X/Y and the game-map lookup for obj_code), and alternating SET/SEND
//   per byte. Generates the 8080-style write strobe (wrx) and chip select (csx) for the panel bus.

---
 rtl/lcd_frame_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lcd_frame_sequencer.sv
// Master sequencer for the LCD command LUT: panel init, then a raster walk of the grid
// on each frame request, driving the LUT mode, cell coordinates and the 8080 wrx/csx strobes.
//
// state       | meaning
// INIT_SET    | LUT presents the next init byte; strobe wrx low unless paused or finished
// INIT_SEND   | init byte on the bus, wrx rises at the end of this cycle
// IDLE        | init done, bus deselected, waiting for a frame request
// CELL_SET    | LUT presents the next byte of the current cell
// CELL_SEND   | cell byte on the bus, wrx rises at the end of this cycle
// CELL_END    | cell finished, LUT rewinds its byte index, step to the next cell
module lcd_frame_sequencer #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       frame_req,
  input  logic       cmd_finished,
  input  logic       lut_pause,
  output logic [2:0] mode,
  output logic [3:0] cell_x,
  output logic [3:0] cell_y,
  output logic       wrx,
  output logic       csx,
  output logic       init_done,
  output logic       frame_busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_INIT_SET,
    S_INIT_SEND,
    S_IDLE,
    S_CELL_SET,
    S_CELL_SEND,
    S_CELL_END
  } state_t;

  localparam logic [2:0] MODE_IDLE   = 3'd0;
  localparam logic [2:0] MODE_SET_I  = 3'd1;
  localparam logic [2:0] MODE_SEND_I = 3'd2;
  localparam logic [2:0] MODE_SET    = 3'd3;
  localparam logic [2:0] MODE_SEND   = 3'd4;

  localparam logic [3:0] LAST_X = 4'(GRID_W - 1);
  localparam logic [3:0] LAST_Y = 4'(GRID_H - 1);

  state_t     state, state_d;
  logic [2:0] mode_d;
  logic [3:0] cell_x_d, cell_y_d;
  logic       wrx_d, csx_d, init_done_d, frame_busy_d, frame_done_d;
  logic       pending, pending_d;
  logic       init_fin, init_fin_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= S_INIT_SET;
      mode       <= MODE_SET_I;
      cell_x     <= '0;
      cell_y     <= '0;
      wrx        <= 1'b1;
      csx        <= 1'b1;
      init_done  <= 1'b0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      pending    <= 1'b0;
      init_fin   <= 1'b0;
    end else begin
      state      <= state_d;
      mode       <= mode_d;
      cell_x     <= cell_x_d;
      cell_y     <= cell_y_d;
      wrx        <= wrx_d;
      csx        <= csx_d;
      init_done  <= init_done_d;
      frame_busy <= frame_busy_d;
      frame_done <= frame_done_d;
      pending    <= pending_d;
      init_fin   <= init_fin_d;
    end
  end

  always_comb begin
    state_d      = state;
    cell_x_d     = cell_x;
    cell_y_d     = cell_y;
    wrx_d        = 1'b1;
    csx_d        = csx;
    init_done_d  = init_done;
    frame_busy_d = frame_busy;
    frame_done_d = 1'b0;
    pending_d    = pending | frame_req;
    init_fin_d   = init_fin;

    case (state)
      S_INIT_SET: begin
        csx_d = 1'b0;
        if (lut_pause) begin
          state_d = S_INIT_SET;
        end else if (cmd_finished) begin
          init_fin_d = 1'b1;
          state_d    = S_INIT_SEND;
        end else begin
          wrx_d      = 1'b0;
          init_fin_d = 1'b0;
          state_d    = S_INIT_SEND;
        end
      end
      S_INIT_SEND: begin
        // init_fin remembers that the preceding SET cycle was the terminator
        if (init_fin) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
          csx_d       = 1'b1;
        end else begin
          state_d = S_INIT_SET;
        end
      end
      S_IDLE: begin
        csx_d = 1'b1;
        if (pending || frame_req) begin
          state_d      = S_CELL_SET;
          pending_d    = 1'b0;
          cell_x_d     = '0;
          cell_y_d     = '0;
          frame_busy_d = 1'b1;
        end
      end
      S_CELL_SET: begin
        csx_d = 1'b0;
        if (cmd_finished) begin
          state_d = S_CELL_END;
        end else begin
          wrx_d   = 1'b0;
          state_d = S_CELL_SEND;
        end
      end
      S_CELL_SEND: begin
        state_d = S_CELL_SET;
      end
      S_CELL_END: begin
        if (cell_x == LAST_X) begin
          cell_x_d = '0;
          if (cell_y == LAST_Y) begin
            cell_y_d     = '0;
            state_d      = S_IDLE;
            frame_busy_d = 1'b0;
            frame_done_d = 1'b1;
            csx_d        = 1'b1;
          end else begin
            cell_y_d = cell_y + 4'd1;
            state_d  = S_CELL_SET;
          end
        end else begin
          cell_x_d = cell_x + 4'd1;
          state_d  = S_CELL_SET;
        end
      end
      default: state_d = S_INIT_SET;
    endcase
  end

  // mode is registered from the next state so it always names the state being entered
  always_comb begin
    mode_d = MODE_IDLE;
    case (state_d)
      S_INIT_SET:  mode_d = MODE_SET_I;
      S_INIT_SEND: mode_d = MODE_SEND_I;
      S_IDLE:      mode_d = MODE_IDLE;
      S_CELL_SET:  mode_d = MODE_SET;
      S_CELL_SEND: mode_d = MODE_SEND;
      S_CELL_END:  mode_d = MODE_SEND;
      default:     mode_d = MODE_IDLE;
    endcase
  end

endmodule
